// File: rtl/mul_seq_xnyn_pkg.sv
`default_nettype none
// ============================================================================
// mul_seq_xnyn_pkg : shared handshake levels, FSM encoding and width helper
//                    for the sequential shift-add multiplier.
// Revision: 1.0
// ============================================================================
package mul_seq_xnyn_pkg;

  localparam logic READY_TRUE  = 1'b1;
  localparam logic READY_FALSE = 1'b0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic int p_width(input int xw, input int yw);
    return xw + yw;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mul_seq_xnyn_step_add.sv
`default_nettype none
// ============================================================================
// mul_step_add : W-bit ripple adder built from a half-adder cell followed by
//                full-adder cells, one per bit.
// Revision: 1.0
// ============================================================================
module mul_step_add #(
  parameter int W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  logic [W:0] carry;

  assign carry[0] = 1'b0;

  for (genvar i = 0; i < W; i++) begin : g_bit
    if (i == 0) begin : g_ha
      assign sum[i]     = a[i] ^ b[i];
      assign carry[i+1] = a[i] & b[i];
    end else begin : g_fa
      assign sum[i]     = a[i] ^ b[i] ^ carry[i];
      assign carry[i+1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  // The accumulator window is sized so the final carry is always zero.
  logic unused_carry;
  assign unused_carry = carry[W];

endmodule
`default_nettype wire

// File: rtl/mul_seq_xnyn.sv
`default_nettype none
// ============================================================================
// mul_seq_xnyn : iterative radix-2 shift-add multiplier, unsigned or signed
//                per operation, one multiplier bit retired per clock.
// Revision: 1.0
// ============================================================================
module mul_seq_xnyn
  import mul_seq_xnyn_pkg::*;
#(
  parameter int X_WIDTH   = 4,
  parameter int Y_WIDTH   = 4,
  parameter int SIGNED_EN = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic                       sgn,
  input  logic [X_WIDTH-1:0]         x,
  input  logic [Y_WIDTH-1:0]         y,
  output logic [X_WIDTH+Y_WIDTH-1:0] p,
  output logic                       s,
  output logic                       rdy,
  output logic                       done
);

  localparam int P_WIDTH = p_width(X_WIDTH, Y_WIDTH);
  localparam int CNT_W   = $clog2(Y_WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(Y_WIDTH - 1);
  localparam logic SGN_OK = (SIGNED_EN != 0);
  localparam logic [P_WIDTH-1:0] WIN_MASK = {{(Y_WIDTH-1){1'b0}}, {(X_WIDTH+1){1'b1}}};

  state_e               state_q, state_d;
  logic [X_WIDTH-1:0]   mx_q, mx_d;
  logic [Y_WIDTH-1:0]   my_q, my_d;
  logic                 neg_q, neg_d;
  logic [P_WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [P_WIDTH-1:0]   p_q, p_d;
  logic                 s_q, s_d;
  logic                 rdy_q, rdy_d;
  logic                 done_q, done_d;

  logic                 sgn_eff;
  logic [X_WIDTH-1:0]   x_mag;
  logic [Y_WIDTH-1:0]   y_mag;
  logic [P_WIDTH-1:0]   acc_shift;
  logic [X_WIDTH:0]     add_a, add_b, add_sum;
  logic [P_WIDTH-1:0]   acc_upd;

  assign sgn_eff = sgn & SGN_OK;
  // Magnitude of the most negative value wraps to itself, which is correct unsigned.
  assign x_mag = (sgn_eff && x[X_WIDTH-1]) ? (~x + {{(X_WIDTH-1){1'b0}}, 1'b1}) : x;
  assign y_mag = (sgn_eff && y[Y_WIDTH-1]) ? (~y + {{(Y_WIDTH-1){1'b0}}, 1'b1}) : y;

  assign acc_shift = acc_q >> cnt_q;
  assign add_a     = acc_shift[X_WIDTH:0];
  assign add_b     = my_q[0] ? {1'b0, mx_q} : '0;
  assign acc_upd   = (acc_q & ~(WIN_MASK << cnt_q))
                   | ({{(Y_WIDTH-1){1'b0}}, add_sum} << cnt_q);

  mul_step_add #(
    .W (X_WIDTH + 1)
  ) u_step_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    state_d = state_q;
    mx_d    = mx_q;
    my_d    = my_q;
    neg_d   = neg_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    s_d     = s_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mx_d    = x_mag;
          my_d    = y_mag;
          neg_d   = sgn_eff & (x[X_WIDTH-1] ^ y[Y_WIDTH-1]);
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        acc_d = acc_upd;
        my_d  = my_q >> 1;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        p_d     = neg_q ? (~acc_q + {{(P_WIDTH-1){1'b0}}, 1'b1}) : acc_q;
        s_d     = neg_q;
        state_d = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    rdy_d  = (state_d == ST_IDLE) ? READY_TRUE : READY_FALSE;
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      mx_q    <= '0;
      my_q    <= '0;
      neg_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
      p_q     <= '0;
      s_q     <= 1'b0;
      rdy_q   <= READY_TRUE;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mx_q    <= mx_d;
      my_q    <= my_d;
      neg_q   <= neg_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      s_q     <= s_d;
      rdy_q   <= rdy_d;
      done_q  <= done_d;
    end
  end

  assign p    = p_q;
  assign s    = s_q;
  assign rdy  = rdy_q;
  assign done = done_q;

endmodule
`default_nettype wire
